// File: rtl/rr_onehot_arbiter_4.sv
// rtl/rr_onehot_arbiter_4.sv - four-requester round-robin arbiter with registered one-hot output stage
// The registered select is always one-hot or zero so it can drive a one-hot mux directly.
module rr_onehot_arbiter_4 #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in0,
  input  logic [WIDTH-1:0] io_in1,
  input  logic [WIDTH-1:0] io_in2,
  input  logic [WIDTH-1:0] io_in3,
  input  logic [N-1:0]     io_req_valid,
  output logic [N-1:0]     io_req_ready,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_data,
  output logic [N-1:0]     io_sel
);

  logic [1:0]       last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [N-1:0]     out_sel_q, out_sel_d;

  logic [1:0]       win;
  logic [N-1:0]     gnt;
  logic             found;
  logic [1:0]       idx;
  logic             can_load;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] in_arr [N];

  assign in_arr[0] = io_in0;
  assign in_arr[1] = io_in1;
  assign in_arr[2] = io_in2;
  assign in_arr[3] = io_in3;

  assign can_load = !out_valid_q || io_out_ready;

  // Search starts one past the last winner; the 2-bit index wraps 3 -> 0 naturally.
  always_comb begin
    gnt   = '0;
    win   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = last_q + 2'(k);
      if (!found && io_req_valid[idx]) begin
        found    = 1'b1;
        win      = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_arr[i] & {WIDTH{gnt[i]}});
    end
  end

  assign io_req_ready = (reset && can_load) ? gnt : '0;

  always_comb begin
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (can_load && gnt != '0) begin
      out_data_d  = sel_data;
      out_sel_d   = gnt;
      out_valid_d = 1'b1;
      last_d      = win;
    end else if (out_valid_q && io_out_ready) begin
      out_valid_d = 1'b0;
      out_sel_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q      <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_data  = out_data_q;
  assign io_sel       = out_sel_q;

endmodule
